// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register constant and the read-port slice helper
// for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  // LSB of read port k's field inside a packed per-port bus of w-bit fields
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: write-to-read bypass mux and load-pending
// (busy) qualification for a single operand.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic wa_hit;
  logic wb_hit;

  assign wa_hit = wa_en && (wa_addr == rd_addr);
  assign wb_hit = wb_en && (wb_addr == rd_addr);

  // Port B outranks port A; a completing load is forwarded, so it never stalls
  always_comb begin
    rd_data = stored_data;
    rd_busy = stored_busy;
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (BYPASS) begin
      if (wb_hit) begin
        rd_data = wb_data;
        rd_busy = 1'b0;
      end else if (wa_hit) begin
        rd_data = wa_data;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write-port, NRD-read-port register file with a pending-load scoreboard,
// a same-address write collision flag and a raw debug read port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       NRD       = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  busy_set_en,
  input  logic [ADDR_W-1:0]     busy_set_addr,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  collision
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              collision_q;
  logic              collision_d;

  logic wa_live;
  logic wb_live;

  assign wa_live = wa_en && (wa_addr != ADDR_W'(REG_ZERO));
  assign wb_live = wb_en && (wb_addr != ADDR_W'(REG_ZERO));

  // Port B is applied last so it wins a same-address write
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wa_live) mem_d[wa_addr] = wa_data;
    if (wb_live) mem_d[wb_addr] = wb_data;
    mem_d[REG_ZERO] = '0;
  end

  // Set is applied after clear: a new load issued behind a completing one stays pending
  always_comb begin
    busy_d = busy_q;
    if (wb_live) busy_d[wb_addr] = 1'b0;
    if (busy_set_en && (busy_set_addr != ADDR_W'(REG_ZERO))) busy_d[busy_set_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_comb begin
    collision_d = wa_live && wb_live && (wa_addr == wb_addr);
  end

  for (genvar i = 0; i < int'(NREG); i++) begin : g_reg
    if (i == 0) begin : g_zero
      always_ff @(posedge clk) begin
        mem_q[i] <= '0;
      end
    end else begin : g_data
      always_ff @(posedge clk) begin
        if (!rst) mem_q[i] <= RESET_VAL;
        else      mem_q[i] <= mem_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      collision_q <= collision_d;
    end
  end

  assign dbg_data  = mem_q[dbg_addr];
  assign collision = collision_q;

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    localparam int unsigned ALSB = port_lsb(unsigned'(k), ADDR_W);
    localparam int unsigned DLSB = port_lsb(unsigned'(k), DATA_W);

    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[ALSB +: ADDR_W];

    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rdport (
      .rd_addr     (addr_k),
      .stored_data (mem_q[addr_k]),
      .stored_busy (busy_q[addr_k]),
      .wa_en       (wa_en),
      .wa_addr     (wa_addr),
      .wa_data     (wa_data),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .rd_data     (rd_data[DLSB +: DATA_W]),
      .rd_busy     (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share
// stimulus and are compared against an array-based architectural model.
module tb_regfile_mp;

  localparam logic [31:0] RV = 32'h0000_000A;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wa_en, wb_en, busy_set_en;
  logic [4:0]  wa_addr, wb_addr, busy_set_addr, dbg_addr;
  logic [31:0] wa_data, wb_data;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] dbg_data_b, dbg_data_n;
  logic        coll_b, coll_n;

  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_coll;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .RESET_VAL(RV), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .collision(coll_b));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .RESET_VAL(RV), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_n), .collision(coll_n));

  // Architectural read value of register a given this cycle's writes
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    if (byp && wa_en && wa_addr == a) return wa_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && wb_en && wb_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = (i == 0) ? 32'h0 : RV;
        m_busy[i] = 1'b0;
      end
      m_coll = 1'b0;
    end else begin
      m_coll = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 5'd0);
      if (wa_en && wa_addr != 5'd0) m_mem[wa_addr] = wa_data;
      if (wb_en && wb_addr != 5'd0) begin
        m_mem[wb_addr]  = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (busy_set_en && busy_set_addr != 5'd0) m_busy[busy_set_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; busy_set_en = 1'b0;
    wa_addr = '0; wb_addr = '0; busy_set_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_addr = '0; dbg_addr = '0;
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_0001;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hDEAD_0002;
    busy_set_en = 1'b1; busy_set_addr = 5'd5;
    tick();
    tick();
    rst = 1'b1;
    idle();
    rd_addr = {5'd6, 5'd5};
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data_b !== 32'h0) begin errors++; $display("FAIL reset_dbg_r0: got %h expected %h", dbg_data_b, 32'h0); end
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (dbg_data_b !== RV) begin errors++; $display("FAIL reset_dbg_r5: got %h expected %h", dbg_data_b, RV); end
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      errors++; $display("FAIL reset_busy: got %b/%b expected 00/00", rd_busy_b, rd_busy_n);
    end
    checks++;
    if (coll_b !== 1'b0 || coll_n !== 1'b0) begin
      errors++; $display("FAIL reset_collision: got %b/%b expected 0/0", coll_b, coll_n);
    end
  endtask

  task automatic test_bypass();
    idle();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h1234_5678;
    rd_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass_wa: got %h expected %h", rd_data_b[31:0], 32'h1234_5678);
    end
    checks++;
    if (rd_data_n[31:0] !== m_mem[3]) begin
      errors++; $display("FAIL nobypass_old: got %h expected %h", rd_data_n[31:0], m_mem[3]);
    end
    tick();
    idle();
    dbg_addr = 5'd3;
    #1;
    checks++;
    if (dbg_data_b !== 32'h1234_5678) begin
      errors++; $display("FAIL dbg_after_write: got %h expected %h", dbg_data_b, 32'h1234_5678);
    end
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hEEEE_EEEE;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0) begin
      errors++; $display("FAIL r0_bypass: got %h/%h expected 0", rd_data_b, rd_data_n);
    end
    tick();
    idle();
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data_b !== 32'h0) begin errors++; $display("FAIL r0_stored: got %h expected 0", dbg_data_b); end
  endtask

  task automatic test_collision();
    idle();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2;
    tick();
    idle();
    dbg_addr = 5'd7;
    #1;
    checks++;
    if (dbg_data_b !== 32'h2) begin errors++; $display("FAIL coll_b_wins: got %h expected %h", dbg_data_b, 32'h2); end
    checks++;
    if (coll_b !== 1'b1 || coll_n !== 1'b1) begin
      errors++; $display("FAIL coll_flag_set: got %b/%b expected 1/1", coll_b, coll_n);
    end
    tick();
    checks++;
    if (coll_b !== 1'b0) begin errors++; $display("FAIL coll_flag_clear: got %b expected 0", coll_b); end
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h2;
    tick();
    idle();
    dbg_addr = 5'd7;
    #1;
    checks++;
    if (dbg_data_b !== 32'h1) begin errors++; $display("FAIL split_r7: got %h expected %h", dbg_data_b, 32'h1); end
    dbg_addr = 5'd8;
    #1;
    checks++;
    if (dbg_data_n !== 32'h2) begin errors++; $display("FAIL split_r8: got %h expected %h", dbg_data_n, 32'h2); end
    checks++;
    if (coll_b !== 1'b0) begin errors++; $display("FAIL split_no_coll: got %b expected 0", coll_b); end
  endtask

  task automatic test_scoreboard();
    idle();
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    rd_addr = {5'd9, 5'd9};
    #1;
    checks++;
    if (rd_busy_b !== 2'b00) begin errors++; $display("FAIL busy_not_yet: got %b expected 00", rd_busy_b); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11) begin
      errors++; $display("FAIL busy_set: got %b/%b expected 11/11", rd_busy_b, rd_busy_n);
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_BEEF;
    #1;
    checks++;
    if (rd_busy_b !== 2'b00 || rd_data_b[63:32] !== 32'h0000_BEEF) begin
      errors++; $display("FAIL busy_forward: got %b %h expected 00 %h", rd_busy_b, rd_data_b[63:32], 32'h0000_BEEF);
    end
    checks++;
    if (rd_busy_n !== 2'b11) begin errors++; $display("FAIL busy_nobypass: got %b expected 11", rd_busy_n); end
    tick();
    idle();
    tick();
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      errors++; $display("FAIL busy_cleared: got %b/%b expected 00/00", rd_busy_b, rd_busy_n);
    end
  endtask

  task automatic test_race();
    idle();
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    tick();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0077;
    tick();
    idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1) begin
      errors++; $display("FAIL race_set_wins: got %b/%b expected 1/1", rd_busy_b[0], rd_busy_n[0]);
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0078;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    busy_set_en = 1'b1; busy_set_addr = 5'd4;
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h55;
    tick();
    idle();
    rd_addr = {5'd4, 5'd4};
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data_b !== 32'h55 || rd_busy_b !== 2'b11) begin
      errors++; $display("FAIL premid_state: got %h %b expected %h 11", dbg_data_b, rd_busy_b, 32'h55);
    end
    rst = 1'b0;
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h99;
    tick();
    rst = 1'b1;
    idle();
    #1;
    checks++;
    if (dbg_data_b !== RV || dbg_data_n !== RV) begin
      errors++; $display("FAIL mid_reset_val: got %h/%h expected %h", dbg_data_b, dbg_data_n, RV);
    end
    checks++;
    if (rd_busy_b !== 2'b00) begin errors++; $display("FAIL mid_reset_busy: got %b expected 00", rd_busy_b); end
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] got, exp;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      wa_en = $urandom_range(0, 1) != 0;
      wb_en = $urandom_range(0, 2) == 0;
      busy_set_en = $urandom_range(0, 2) == 0;
      wa_addr = 5'($urandom_range(0, 7));
      wb_addr = 5'($urandom_range(0, 7));
      busy_set_addr = 5'($urandom_range(0, 7));
      wa_data = $urandom;
      wb_data = $urandom;
      rd_addr = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      dbg_addr = 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        got = rd_data_b[k*32 +: 32];
        exp = exp_rd(a, 1'b1);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_rd_byp p%0d a%0d: got %h expected %h", k, a, got, exp); end
        got = rd_data_n[k*32 +: 32];
        exp = exp_rd(a, 1'b0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_rd_nobyp p%0d a%0d: got %h expected %h", k, a, got, exp); end
        checks++;
        if (rd_busy_b[k] !== exp_busy(a, 1'b1) || rd_busy_n[k] !== exp_busy(a, 1'b0)) begin
          errors++;
          $display("FAIL rand_busy p%0d a%0d: got %b/%b expected %b/%b", k, a, rd_busy_b[k], rd_busy_n[k],
                   exp_busy(a, 1'b1), exp_busy(a, 1'b0));
        end
      end
      checks++;
      if (dbg_data_b !== m_mem[dbg_addr] || dbg_data_n !== m_mem[dbg_addr]) begin
        errors++; $display("FAIL rand_dbg a%0d: got %h/%h expected %h", dbg_addr, dbg_data_b, dbg_data_n, m_mem[dbg_addr]);
      end
      checks++;
      if (coll_b !== m_coll || coll_n !== m_coll) begin
        errors++; $display("FAIL rand_coll: got %b/%b expected %b", coll_b, coll_n, m_coll);
      end
      tick();
    end
    rst = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_race();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
